// File: rtl/bpred_pkg.sv
// Shared constants, entry layout and FSM encoding for the jump prediction table write path.
// Entry word: {tag, target, state}; a state of STATE_INVALID makes the reader predict 16'hFFFF.
package bpred_pkg;

  localparam int IDX_W    = 5;
  localparam int TAG_W    = 11;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 1 << IDX_W;
  localparam int ENTRY_W  = TAG_W + ADDR_W + 2;
  localparam int TAG_LSB  = 18;
  localparam int ADDR_LSB = 2;

  localparam logic [1:0] STATE_INVALID = 2'b00;
  localparam logic [1:0] STATE_VALID   = 2'b01;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } updState_t;

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [ENTRY_W-1:0] data;
  } updEntry_t;

  function automatic updEntry_t mkEntry(input logic [ADDR_W-1:0] pc,
                                        input logic [ADDR_W-1:0] target);
    updEntry_t e;
    e.idx  = pc[IDX_W-1:0];
    e.data = {pc[ADDR_W-1:IDX_W], target, STATE_VALID};
    return e;
  endfunction

endpackage

// File: rtl/bpred_update_ctrl_if.sv
// Resolved-jump update bus from the two requesters ([0]=EX, [1]=WB).
// Transfer on a lane happens in any cycle where req_valid & req_ready are both high.
interface bpred_update_ctrl_if;
  import bpred_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][ADDR_W-1:0] req_pc;
  logic [1:0][ADDR_W-1:0] req_target;

  modport master (output req_valid, output req_pc, output req_target, input req_ready);
  modport slave  (input req_valid, input req_pc, input req_target, output req_ready);
endinterface

// File: rtl/bpred_upd_fifo.sv
// Synchronous FIFO for pending table updates; one push and one pop per cycle, flush empties it.
// Zero added latency beyond the clock edge; push is ignored when full, pop ignored when empty.
module bpred_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign doPush  = push && !full && !flush;
  assign doPop   = pop && !empty && !flush;
  assign popData = mem[rdPtr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Write-side controller for the jump prediction table: RR-arbitrated EX/WB updates, queued, one write/cycle, plus flush sweep.
// Accept at cycle N -> table write at N+1 earliest; ready drops when queue full, during sweep and on flush_req.
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bpred_update_ctrl_if.slave   upd,
  input  logic                 flush_req,
  output logic                 tbl_wr_en,
  output logic [IDX_W-1:0]     tbl_wr_idx,
  output logic [ENTRY_W-1:0]   tbl_wr_data,
  output logic                 busy,
  output logic                 clear_done,
  output logic [7:0]           drop_cnt
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  updState_t       state;
  logic            rrPtr;
  logic [1:0]      grant;
  logic            grantSel;
  logic            acceptOk;
  logic            accept;
  logic            flushNow;
  logic            fifoPush;
  logic            fifoPop;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [CW-1:0]   fifoCnt;
  logic            drainNext;
  logic [8:0]      dropSum;
  updEntry_t       reqEntry;
  updEntry_t       headEntry;

  // Both valid: the pointer side wins; a lone requester wins regardless.
  always_comb begin
    grant = upd.req_valid;
    if (&upd.req_valid) grant = rrPtr ? 2'b10 : 2'b01;
  end

  assign grantSel      = grant[1];
  assign flushNow      = flush_req && (state != ST_CLEAR);
  assign acceptOk      = !fifoFull && (state != ST_CLEAR) && !flush_req;
  assign upd.req_ready = acceptOk ? grant : 2'b00;
  assign accept        = |(upd.req_valid & upd.req_ready);
  assign reqEntry      = mkEntry(upd.req_pc[grantSel], upd.req_target[grantSel]);

  // An accept into an empty queue bypasses storage and goes straight to the write port.
  assign fifoPop   = !fifoEmpty && !flushNow && (state != ST_CLEAR);
  assign fifoPush  = accept && !fifoEmpty;
  assign drainNext = !fifoEmpty && !((fifoCnt == CNT_ONE) && fifoPop && !fifoPush);
  assign dropSum   = {1'b0, drop_cnt} + 9'(fifoCnt);
  assign busy      = !fifoEmpty || (state == ST_CLEAR);

  bpred_upd_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(updEntry_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifoPush),
    .pushData (reqEntry),
    .pop      (fifoPop),
    .popData  (headEntry),
    .flush    (flushNow),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rrPtr       <= 1'b0;
      tbl_wr_en   <= 1'b0;
      tbl_wr_idx  <= '0;
      tbl_wr_data <= '0;
      clear_done  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      clear_done <= 1'b0;
      if (accept) rrPtr <= ~grantSel;
      if (flushNow) begin
        state       <= ST_CLEAR;
        tbl_wr_en   <= 1'b1;
        tbl_wr_idx  <= '0;
        tbl_wr_data <= '0;
        drop_cnt    <= dropSum[8] ? 8'hFF : dropSum[7:0];
      end else if (state == ST_CLEAR) begin
        // The write index register doubles as the sweep counter.
        if (tbl_wr_idx == LAST_IDX) begin
          state      <= ST_IDLE;
          tbl_wr_en  <= 1'b0;
          clear_done <= 1'b1;
        end else begin
          tbl_wr_en   <= 1'b1;
          tbl_wr_idx  <= tbl_wr_idx + IDX_ONE;
          tbl_wr_data <= '0;
        end
      end else begin
        state <= drainNext ? ST_DRAIN : ST_IDLE;
        if (fifoPop) begin
          tbl_wr_en   <= 1'b1;
          tbl_wr_idx  <= headEntry.idx;
          tbl_wr_data <= headEntry.data;
        end else if (accept) begin
          tbl_wr_en   <= 1'b1;
          tbl_wr_idx  <= reqEntry.idx;
          tbl_wr_data <= reqEntry.data;
        end else begin
          tbl_wr_en <= 1'b0;
        end
      end
    end
  end

endmodule
